fib_step_arbiter: RTL
=====================

# fib_step_arbiter

Scheduler for the two-phase bounded counter datapath (x, y) used in the arithmetic invariant cases. Two requesters share the datapath through a round-robin arbiter, and every granted request advances it by exactly one loop iteration. A phase FSM sequences the datapath: x-only increments, then joint x/y increments, then terminal hold. For the default parameters, the invariant `(x < X_LIMIT) || (y == Y_LIMIT)` holds by construction.

## Interface
Parameters:
- W, 11, width of x and y
- X_SPLIT, 100, last x value reached in phase 1
- X_LIMIT, 200, terminal x value
- Y_INIT, 100, y value loaded on reset and start
- Y_LIMIT, 200, y saturation value

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  (re)initialise datapath and enter phase 1
- req0  in  1  requester 0 asks for one step this cycle
- req1  in  1  requester 1 asks for one step this cycle
- gnt0  out  1  combinational; step from requester 0 taken at this edge
- gnt1  out  1  combinational; step from requester 1 taken at this edge
- x  out  W  registered counter x
- y  out  W  registered counter y
- phase  out  2  registered FSM state: 0 IDLE, 1 RUN1, 2 RUN2, 3 DONE
- done  out  1  registered, equals (phase == DONE)
- sat  out  1  registered; DONE was entered via y saturation, not via x limit

## Operation
- **FSM states:** IDLE, RUN1, RUN2, DONE.
- **Reset:** phase=IDLE, x=0, y=Y_INIT, done=0, sat=0, round-robin pointer favours req0.
- **start:** highest priority in every state. Next state is RUN1, x=0, y=Y_INIT, sat=0. No grant is issued in that cycle.
- **IDLE and DONE:** x and y hold. gnt0=gnt1=0 regardless of the request inputs.
- **Step-enable condition:** phase is RUN1 or RUN2, start=0, and (req0 | req1).
- **Arbitration:** round-robin.
  - With one request pending, that requester is granted.
  - With both pending, the requester not granted last is granted.
  - The pointer updates only on an actual grant.
  - At most one grant is issued per cycle; gnt0 and gnt1 are never both high.
- **RUN1 step:** x <= x+1, y holds. If x+1 == X_SPLIT, next phase is RUN2.
- **RUN2 step:** x <= x+1, y <= y+1.
  - If x+1 == X_LIMIT, next phase is DONE.
  - Otherwise, if y+1 == Y_LIMIT, next phase is DONE and sat <= 1.
- **No step in RUN1/RUN2:** x, y and phase hold.
- **Arithmetic:** unsigned W-bit values. Comparisons use the incremented value, computed W+1 bits wide, so no wrap is possible. x never exceeds X_LIMIT and y never exceeds Y_LIMIT.
- **Default parameter behaviour:** X_LIMIT−X_SPLIT == Y_LIMIT−Y_INIT, so DONE is reached with x=200, y=200, sat=0.

## Timing
- **Grant latency:** a grant is visible in the same cycle as the request. The datapath update is visible in the next cycle.
- **Throughput:** one step per cycle maximum.
- **Requester semantics:** a requester that keeps req high receives one step per grant. A request that is not granted is not queued; the requester re-asserts it.
- **start latency:** start in cycle N gives phase=RUN1, x=0, y=Y_INIT in cycle N+1. The first grant is possible in cycle N+1.
- **Full run length:** exactly X_LIMIT granted steps from start to DONE (200 by default). The RUN1→RUN2 transition is visible after step X_SPLIT, with x=100, y=100.
- **Simultaneous events:**
  - start with req: start wins, and no grant is issued.
  - rst with anything: rst wins.
- **Reset mid-run:** returns to IDLE with reset values. A start is then required to run again.

## Test plan
- **Reset and idle:** apply rst, then hold req0=req1=1 for 5 cycles with no start. Required: phase=0, x=0, y=100, gnt0=gnt1=0 throughout.
- **Single requester full run:** pulse start, then hold req0=1. Required:
  - gnt0 high for 200 consecutive cycles.
  - x=100, y=100, phase=2 after step 100.
  - x=200, y=200, phase=3, done=1, sat=0 after step 200.
  - gnt0=0 afterward.
- **Contention:** pulse start, then hold req0=req1=1 for 6 cycles. Required: grants alternate 0,1,0,1,0,1; x=6; y=100.
- **Restart mid-RUN2:** run to x=150, y=150, then assert start together with req1. Required: gnt1=0 that cycle; next cycle phase=1, x=0, y=100.
- **Saturation:** configure Y_INIT=150 and run to completion. Required: DONE at x=150, y=200, sat=1.
- **Invariant check:** random req0/req1/start stimulus over 10k cycles. Required:
  - (x<200)||(y==200) holds at every cycle.
  - gnt0 and gnt1 are never both high.

Source files
------------

// File: rtl/fib_step_arbiter_if.sv
// Request/grant handshake and datapath observation bundle for fib_step_arbiter.
// The master side issues start/requests; the slave side (the arbiter) returns grants and state.
interface fib_step_arbiter_if #(
  parameter int W = 11
);
  logic         start;
  logic         req0;
  logic         req1;
  logic         gnt0;
  logic         gnt1;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [1:0]   phase;
  logic         done;
  logic         sat;

  modport master (
    output start, req0, req1,
    input  gnt0, gnt1, x, y, phase, done, sat
  );

  modport slave (
    input  start, req0, req1,
    output gnt0, gnt1, x, y, phase, done, sat
  );
endinterface

// File: rtl/fib_step_arbiter.sv
// Round-robin scheduler for the two-phase bounded (x, y) counter datapath.
// Each grant advances the datapath by one loop iteration; start re-initialises it.
module fib_step_arbiter #(
  parameter int W       = 11,
  parameter int X_SPLIT = 100,
  parameter int X_LIMIT = 200,
  parameter int Y_INIT  = 100,
  parameter int Y_LIMIT = 200
) (
  input logic              clk,
  input logic              rst,
  fib_step_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN1 = 2'd1,
    RUN2 = 2'd2,
    DONE = 2'd3
  } phase_t;

  localparam logic [W:0]   XSPLIT_V = (W+1)'(X_SPLIT);
  localparam logic [W:0]   XLIMIT_V = (W+1)'(X_LIMIT);
  localparam logic [W:0]   YLIMIT_V = (W+1)'(Y_LIMIT);
  localparam logic [W-1:0] YINIT_V  = W'(Y_INIT);

  phase_t       state_q, state_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic         sat_q, sat_d;
  logic         done_q;
  logic         last1_q, last1_d;
  logic         running;
  logic         step;
  logic         pick1;
  logic [W:0]   x_inc;
  logic [W:0]   y_inc;

  // Increments carry one extra bit so the limit compares can never see a wrapped value.
  assign x_inc   = {1'b0, x_q} + {{W{1'b0}}, 1'b1};
  assign y_inc   = {1'b0, y_q} + {{W{1'b0}}, 1'b1};
  assign running = (state_q == RUN1) || (state_q == RUN2);
  assign step    = running && !bus.start && (bus.req0 || bus.req1);
  // last1_q remembers which requester won last; under contention the other one wins.
  assign pick1   = bus.req1 && (!bus.req0 || !last1_q);

  assign bus.gnt0  = step && !pick1;
  assign bus.gnt1  = step && pick1;
  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.phase = state_q;
  assign bus.done  = done_q;
  assign bus.sat   = sat_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sat_d   = sat_q;
    last1_d = last1_q;
    if (bus.start) begin
      state_d = RUN1;
      x_d     = '0;
      y_d     = YINIT_V;
      sat_d   = 1'b0;
    end else if (step) begin
      last1_d = pick1;
      x_d     = x_inc[W-1:0];
      case (state_q)
        RUN1: begin
          if (x_inc == XSPLIT_V) state_d = RUN2;
        end
        RUN2: begin
          y_d = y_inc[W-1:0];
          // The x limit takes precedence; saturation only marks an early stop on y.
          if (x_inc == XLIMIT_V) begin
            state_d = DONE;
          end else if (y_inc == YLIMIT_V) begin
            state_d = DONE;
            sat_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= YINIT_V;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      last1_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      done_q  <= (state_d == DONE);
      last1_q <= last1_d;
    end
  end

endmodule
